// File: rtl/irq_conditioner_pkg.sv
// Shared constants, register map and config payload for the interrupt conditioner.
package irq_conditioner_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OFF_W       = 12;
  localparam int unsigned PAGE_W      = ADDR_W - OFF_W;
  localparam int unsigned IRQ_COUNT   = 32;
  localparam int unsigned FILTER_BITS = 4;
  localparam int unsigned WARM_W      = 2;

  // Page sits just below the 0xfffff000 interrupt-block page.
  localparam logic [ADDR_W-1:0] IRQC_BASE = 32'hffff_e000;

  typedef enum logic [OFF_W-1:0] {
    REG_MODE     = 12'h000,
    REG_POLARITY = 12'h001,
    REG_ENABLE   = 12'h002,
    REG_FILTER   = 12'h003,
    REG_STATUS   = 12'h004,
    REG_SOFT     = 12'h005
  } reg_off_e;

  typedef struct packed {
    logic [IRQ_COUNT-1:0]   mode;
    logic [IRQ_COUNT-1:0]   pol;
    logic [IRQ_COUNT-1:0]   en;
    logic [FILTER_BITS-1:0] filter;
  } cfg_t;

  // All lines edge-triggered, active-high, disabled, unfiltered.
  localparam cfg_t CFG_RESET = '{mode: '1, pol: '0, en: '0, filter: '0};

  // True when an address page matches the block's page.
  function automatic logic page_hit(input logic [PAGE_W-1:0] addr_page,
                                    input logic [PAGE_W-1:0] base_page);
    return addr_page == base_page;
  endfunction

endpackage

// File: rtl/irq_conditioner_if.sv
// Tenyr data-bus request signals (strobe/rw/address) seen by the conditioner.
interface irq_conditioner_if;
  import irq_conditioner_pkg::*;

  logic              strobe;
  logic              rw;
  logic [ADDR_W-1:0] d_addr;

  modport master (output strobe, rw, d_addr);
  modport slave  (input  strobe, rw, d_addr);
endinterface

// File: rtl/irq_line.sv
// One interrupt line: 2-flop synchroniser, stability filter, edge/level qualification.
module irq_line
  import irq_conditioner_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   raw_i,
  input  logic                   mode_i,
  input  logic                   pol_i,
  input  logic                   en_i,
  input  logic                   warm_i,
  input  logic [FILTER_BITS-1:0] filter_i,
  input  logic                   filter_clr_i,
  output logic                   stable_o,
  output logic                   pulse_o_c
);

  logic                   s0_q, s1_q;
  logic                   stable_q, stable_d;
  logic [FILTER_BITS-1:0] cnt_q, cnt_d;
  logic                   expire_c;
  logic                   edge_c;
  logic                   level_c;

  // Filter: stable follows s1 only after it has disagreed for filter_i+1 cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    expire_c = 1'b0;
    if (!warm_i) begin
      // Track silently so lines held active through reset give no edge.
      stable_d = s1_q;
      cnt_d    = '0;
    end else if (filter_clr_i || (s1_q == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == filter_i) begin
      stable_d = s1_q;
      cnt_d    = '0;
      expire_c = 1'b1;
    end else begin
      cnt_d = cnt_q + FILTER_BITS'(1);
    end
  end

  // Edge pulse fires in the cycle stable moves toward the active level.
  assign edge_c    = expire_c & (s1_q ^ pol_i);
  assign level_c   = stable_q ^ pol_i;
  assign pulse_o_c = (mode_i ? edge_c : level_c) & en_i & warm_i;
  assign stable_o  = stable_q;

  // Synchroniser, filter counter and stable level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s0_q     <= raw_i;
      s1_q     <= s0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/irq_conditioner.sv
// Interrupt front end: bus-mapped config, per-line conditioning, registered irq output.
module irq_conditioner
  import irq_conditioner_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = IRQC_BASE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IRQ_COUNT-1:0] irq_raw,
  irq_conditioner_if.slave     bus,
  inout  wire  [DATA_W-1:0]    d_data,
  output logic [IRQ_COUNT-1:0] irq
);

  logic                 sel_c, wr_c, rd_c, filter_clr_c, warm_c;
  logic [OFF_W-1:0]     off_c;
  cfg_t                 cfg_q, cfg_d;
  logic [IRQ_COUNT-1:0] soft_q, soft_d;
  logic [IRQ_COUNT-1:0] irq_q, irq_d;
  logic [IRQ_COUNT-1:0] stable_vec;
  logic [IRQ_COUNT-1:0] pulse_vec_c;
  logic [DATA_W-1:0]    rdata_q, rdata_d, rmux_c;
  logic [WARM_W-1:0]    warm_q, warm_d;

  // Bus decode.
  assign sel_c        = page_hit(bus.d_addr[ADDR_W-1:OFF_W], BASE_ADDR[ADDR_W-1:OFF_W]);
  assign off_c        = bus.d_addr[OFF_W-1:0];
  assign wr_c         = sel_c & bus.strobe & bus.rw;
  assign rd_c         = sel_c & bus.strobe & ~bus.rw;
  assign filter_clr_c = wr_c & (off_c == REG_FILTER);
  assign warm_c       = (warm_q == '1);

  // Previously captured read data goes out on a strobed read of this page.
  assign d_data = rd_c ? rdata_q : 'z;
  assign irq    = irq_q;

  // Per-line conditioning.
  for (genvar g = 0; g < IRQ_COUNT; g++) begin : g_line
    irq_line u_line (
      .clk          (clk),
      .reset_n      (reset_n),
      .raw_i        (irq_raw[g]),
      .mode_i       (cfg_q.mode[g]),
      .pol_i        (cfg_q.pol[g]),
      .en_i         (cfg_q.en[g]),
      .warm_i       (warm_c),
      .filter_i     (cfg_q.filter),
      .filter_clr_i (filter_clr_c),
      .stable_o     (stable_vec[g]),
      .pulse_o_c    (pulse_vec_c[g])
    );
  end

  // Register read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rmux_c = '0;
    case (off_c)
      REG_MODE:     rmux_c = DATA_W'(cfg_q.mode);
      REG_POLARITY: rmux_c = DATA_W'(cfg_q.pol);
      REG_ENABLE:   rmux_c = DATA_W'(cfg_q.en);
      REG_FILTER:   rmux_c = DATA_W'(cfg_q.filter);
      REG_STATUS:   rmux_c = DATA_W'(stable_vec);
      default:      rmux_c = '0;
    endcase
  end

  // Next state for config, soft pulses, read capture, warmup and output.
  always_comb begin
    cfg_d   = cfg_q;
    soft_d  = '0;
    rdata_d = rdata_q;
    warm_d  = warm_c ? warm_q : warm_q + WARM_W'(1);
    if (wr_c) begin
      case (off_c)
        REG_MODE:     cfg_d.mode   = d_data[IRQ_COUNT-1:0];
        REG_POLARITY: cfg_d.pol    = d_data[IRQ_COUNT-1:0];
        REG_ENABLE:   cfg_d.en     = d_data[IRQ_COUNT-1:0];
        REG_FILTER:   cfg_d.filter = d_data[FILTER_BITS-1:0];
        REG_SOFT:     soft_d       = d_data[IRQ_COUNT-1:0];
        default:      cfg_d        = cfg_q;
      endcase
    end
    if (rd_c) begin
      rdata_d = rmux_c;
    end
    irq_d = pulse_vec_c | soft_q;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_q   <= CFG_RESET;
      soft_q  <= '0;
      rdata_q <= '0;
      warm_q  <= '0;
      irq_q   <= '0;
    end else begin
      cfg_q   <= cfg_d;
      soft_q  <= soft_d;
      rdata_q <= rdata_d;
      warm_q  <= warm_d;
      irq_q   <= irq_d;
    end
  end

endmodule
